// File: rtl/mem_request_arbiter.sv
// rtl/mem_request_arbiter.sv - round-robin arbiter sharing one memory port among NUM_CH requestors
module mem_request_arbiter #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [NUM_CH-1:0]        select_i,
   input  logic [NUM_CH*ADDR_W-1:0] addr_i,
   input  logic                     inval_i,
   output logic [NUM_CH-1:0]        busy_o,
   output logic [NUM_CH-1:0]        permit_o,
   output logic [NUM_CH-1:0]        done_o,
   output logic                     mem_req_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   input  logic                     mem_resp_i
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e            state_q;
   logic [IDX_W-1:0]  owner_q;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [IDX_W-1:0]  rr_ptr_d;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [NUM_CH-1:0] permit_q;
   logic [NUM_CH-1:0] last_valid_q;
   logic [ADDR_W-1:0] last_addr_q [NUM_CH];

   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] owned;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] done;
   logic              grant_vld;
   logic [IDX_W-1:0]  grant_idx;
   logic [ADDR_W-1:0] grant_addr;

   // Per-channel classification: already satisfied, in flight, or needing a new transaction
   always_comb begin
      hit     = '0;
      owned   = '0;
      pending = '0;
      done    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         hit[c]     = last_valid_q[c] && (addr_i[c*ADDR_W +: ADDR_W] == last_addr_q[c]);
         owned[c]   = (state_q == BUSY) && (owner_q == IDX_W'(c));
         pending[c] = select_i[c] & ~hit[c] & ~owned[c];
         done[c]    = mem_resp_i & owned[c];
      end
   end

   // Round-robin search: first pending channel at or above rr_ptr, wrapping around
   always_comb begin
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_addr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!grant_vld && pending[(int'(rr_ptr_q) + i) % NUM_CH]) begin
            grant_vld  = 1'b1;
            grant_idx  = IDX_W'((int'(rr_ptr_q) + i) % NUM_CH);
            grant_addr = addr_i[((int'(rr_ptr_q) + i) % NUM_CH)*ADDR_W +: ADDR_W];
         end
      end
      rr_ptr_d = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
   end

   // Transaction FSM: grant in IDLE, hold owner/address through BUSY until mem_resp
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         mem_addr_q <= '0;
         permit_q   <= '0;
      end else begin
         permit_q <= '0;
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  state_q    <= BUSY;
                  owner_q    <= grant_idx;
                  mem_addr_q <= grant_addr;
                  rr_ptr_q   <= rr_ptr_d;
                  permit_q   <= NUM_CH'(1) << grant_idx;
               end
            end
            BUSY: begin
               if (mem_resp_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Completed-address records; invalidation overrides a same-cycle completion
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_valid_q <= '0;
         for (int c = 0; c < NUM_CH; c++) last_addr_q[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (done[c]) last_addr_q[c] <= mem_addr_q;
            if (inval_i)      last_valid_q[c] <= 1'b0;
            else if (done[c]) last_valid_q[c] <= 1'b1;
         end
      end
   end

   assign mem_req_o  = (state_q == BUSY);
   assign mem_addr_o = mem_addr_q;
   assign permit_o   = permit_q;
   assign done_o     = done;
   assign busy_o     = select_i & ~hit & ~done;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb/tb_mem_request_arbiter.sv - self-checking bench for mem_request_arbiter
module tb_mem_request_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    select;
   logic [N*AW-1:0] addr;
   logic            inval;
   logic [N-1:0]    busy_o, permit_o, done_o;
   logic            mem_req_o;
   logic [AW-1:0]   mem_addr_o;
   logic            mem_resp;

   int errors = 0;
   int checks = 0;

   // reference model: transaction-level view of the shared port
   bit            m_busy;
   int            m_owner;
   int            m_ptr;
   int            m_permit_ch;
   logic [AW-1:0] m_maddr;
   bit            m_valid [N];
   logic [AW-1:0] m_last  [N];

   mem_request_arbiter #(.NUM_CH(N), .ADDR_W(AW)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .select_i   (select),
      .addr_i     (addr),
      .inval_i    (inval),
      .busy_o     (busy_o),
      .permit_o   (permit_o),
      .done_o     (done_o),
      .mem_req_o  (mem_req_o),
      .mem_addr_o (mem_addr_o),
      .mem_resp_i (mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_permit_ch = -1; m_maddr = '0;
      for (int c = 0; c < N; c++) begin m_valid[c] = 0; m_last[c] = '0; end
   endtask

   task automatic set_addr(input int c, input logic [AW-1:0] v);
      addr[c*AW +: AW] = v;
   endtask

   // check this cycle's outputs against the model, then advance one clock
   task automatic cyc();
      logic [N-1:0] e_done, e_busy, e_perm;
      bit           hitv [N];
      int           gch;
      #1;
      for (int c = 0; c < N; c++) begin
         hitv[c]   = m_valid[c] && (m_last[c] == addr[c*AW +: AW]);
         e_done[c] = m_busy && mem_resp && (m_owner == c);
         e_busy[c] = select[c] && !hitv[c] && !e_done[c];
         e_perm[c] = (m_permit_ch == c);
      end
      chk("mem_req",  32'(mem_req_o), 32'(m_busy));
      chk("mem_addr", mem_addr_o, m_maddr);
      chk("permit",   32'(permit_o), 32'(e_perm));
      chk("done",     32'(done_o), 32'(e_done));
      chk("busy",     32'(busy_o), 32'(e_busy));
      gch = -1;
      if (!m_busy)
         for (int k = 0; k < N; k++)
            if (gch < 0 && select[(m_ptr + k) % N] && !hitv[(m_ptr + k) % N]) gch = (m_ptr + k) % N;
      @(posedge clk);
      m_permit_ch = -1;
      if (m_busy) begin
         if (mem_resp) begin
            m_last[m_owner]  = m_maddr;
            m_valid[m_owner] = 1;
            m_busy = 0;
         end
      end else if (gch >= 0) begin
         m_busy = 1; m_owner = gch; m_maddr = addr[gch*AW +: AW];
         m_ptr = (gch + 1) % N; m_permit_ch = gch;
      end
      if (inval) for (int c = 0; c < N; c++) m_valid[c] = 0;
      @(negedge clk);
   endtask

   // advance until the first BUSY cycle of a new transaction
   task automatic wait_grant();
      for (int i = 0; i < 20 && !m_busy; i++) cyc();
      chk("grant_timeout", 32'(m_busy), 32'd1);
   endtask

   initial begin
      logic [N-1:0] got;
      int           ch;
      rst_n = 0; select = '0; addr = '0; inval = 0; mem_resp = 0;
      model_reset();
      repeat (2) @(negedge clk);
      cyc();
      select = 2'b11;
      #1 chk("rst_busy_follows_select", 32'(busy_o), 32'h3);
      select = '0;
      rst_n  = 1;

      // single transaction on channel 0, mem_resp in cycle 4
      select = 2'b01; set_addr(0, 32'h100);
      cyc();
      chk("t1_mem_addr", mem_addr_o, 32'h100);
      chk("t1_permit", 32'(permit_o), 32'h1);
      repeat (3) cyc();
      mem_resp = 1; cyc(); mem_resp = 0;
      repeat (3) cyc();
      chk("t1_no_reissue", 32'(mem_req_o), 32'h0);

      // new address on the same channel
      set_addr(0, 32'h104);
      wait_grant();
      chk("t2_mem_addr", mem_addr_o, 32'h104);
      repeat (2) cyc();
      mem_resp = 1; cyc(); mem_resp = 0;

      // inval coinciding with completion of 0x200 on channel 1
      select = 2'b10; set_addr(1, 32'h200);
      wait_grant();
      cyc();
      mem_resp = 1; inval = 1; cyc(); mem_resp = 0; inval = 0;
      chk("t4_inval_rerequest", 32'(busy_o[1]), 32'h1);
      wait_grant();
      chk("t4_reissue_addr", mem_addr_o, 32'h200);
      cyc();
      mem_resp = 1; cyc(); mem_resp = 0;

      // round-robin with both channels continuously requesting
      select = 2'b11; set_addr(0, 32'h1000); set_addr(1, 32'h2000);
      for (int k = 0; k < 4; k++) begin
         wait_grant();
         got = permit_o;
         chk("rr_order", 32'(got), (k % 2 == 0) ? 32'h1 : 32'h2);
         cyc();
         ch = m_owner;
         mem_resp = 1; cyc(); mem_resp = 0;
         set_addr(ch, addr[ch*AW +: AW] + 32'h4);
      end

      // address change while in flight
      select = 2'b01; set_addr(0, 32'h300);
      wait_grant();
      chk("t5_latched_addr", mem_addr_o, 32'h300);
      cyc();
      set_addr(0, 32'h304);
      cyc();
      mem_resp = 1; cyc(); mem_resp = 0;
      wait_grant();
      chk("t5_new_addr", mem_addr_o, 32'h304);

      // select dropped while in flight
      select = 2'b00;
      cyc();
      mem_resp = 1;
      #1 chk("t5_drop_done", 32'(done_o), 32'h1);
      cyc(); mem_resp = 0;

      // asynchronous reset in BUSY cycle 2
      select = 2'b01; set_addr(0, 32'h500);
      wait_grant();
      cyc();
      #1 rst_n = 0;
      #1 chk("t6_req_dropped", 32'(mem_req_o), 32'h0);
      chk("t6_mem_addr_cleared", mem_addr_o, 32'h0);
      model_reset();
      @(posedge clk); @(negedge clk);
      rst_n = 1; select = '0; mem_resp = 1;
      cyc();
      mem_resp = 0; select = 2'b01; set_addr(0, 32'h304);
      cyc();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         select   = N'($urandom);
         for (int c = 0; c < N; c++) set_addr(c, 32'h10 + 32'h4 * $urandom_range(0, 3));
         mem_resp = 1'($urandom_range(0, 1));
         inval    = ($urandom_range(0, 9) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Parametrised successor to the single-channel request blocking logic. It gives NUM_CH requestors (fetch, data, prefetch…) shared access to one downstream memory port. The block decides for each channel whether a request is new (address differs from the last one it completed) or already satisfied. It issues one downstream transaction at a time, arbitrated round-robin, and produces per-channel busy, permit and done indications. It sits between the pipeline-side cache/fetch requestors and the shared memory/arbiter interface.

## Interface
- NUM_CH, 2, number of requestor channels (1..8)
- ADDR_W, 32, address width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- select  in  NUM_CH  channel c wants access at addr[c]
- addr  in  NUM_CH*ADDR_W  channel c address in bits [c*ADDR_W +: ADDR_W]
- inval  in  1  clears every channel's completed-address record
- busy  out  NUM_CH  channel c must stall
- permit  out  NUM_CH  one-cycle pulse: channel c's request issued downstream
- done  out  NUM_CH  one-cycle pulse: channel c's request completed this cycle
- mem_req  out  1  downstream request valid
- mem_addr  out  ADDR_W  downstream address (latched at grant)
- mem_resp  in  1  downstream completion, single cycle

## Operation
- Per-channel state: last_valid[c] (1 bit) and last_addr[c] (ADDR_W).
- hit[c] = last_valid[c] & (addr[c] == last_addr[c]).
- pending[c] = select[c] & ~hit[c] & ~(state==BUSY & owner==c).
- FSM states: IDLE and BUSY. Owner register: clog2(NUM_CH) bits, minimum 1. rr_ptr register: same width.
- IDLE: if any pending, grant to the first pending channel searching upward from rr_ptr with wrap. On the edge: owner←grant, mem_addr←addr[grant], rr_ptr←(grant+1) mod NUM_CH, state←BUSY. If nothing is pending, stay in IDLE.
- BUSY: mem_req=1. On mem_resp: last_addr[owner]←mem_addr, last_valid[owner]←1, state←IDLE.
- permit[c] = 1 in the first BUSY cycle after a grant to c. This is a registered pulse.
- done[c] = mem_resp & (state==BUSY) & (owner==c). This is combinational.
- busy[c] = select[c] & ~hit[c] & ~done[c]. A stalled channel is released in its completion cycle.
- mem_resp while in IDLE is ignored.
- inval: on the edge, clears all last_valid. If inval coincides with a completion, inval wins: the record is cleared.
- Address change while c's transaction is in flight: the transaction completes with the latched address. The new address then misses and raises a fresh request.
- select drop while in flight: the transaction is not aborted. done still pulses and the record is updated.
- NUM_CH=1: the arbiter degenerates to that channel. rr_ptr stays 0.

## Timing
- Reset values: state=IDLE, owner=0, rr_ptr=0, last_valid=0, last_addr=0, mem_addr=0. Outputs mem_req=0, permit=0, done=0. busy follows select combinationally, because all records are invalid.
- Reset is asynchronous. Asserting it mid-transaction drops mem_req immediately. An outstanding mem_resp after reset is ignored.
- Latency: request visible in cycle 0 with FSM idle → mem_req and permit in cycle 1 → completion in cycle k (mem_resp) → busy low in cycle k, done in cycle k → IDLE in cycle k+1.
- One mandatory IDLE cycle separates transactions. The next grant is at the end of cycle k+1 and its mem_req is in cycle k+2.
- mem_addr and owner are stable for the whole of BUSY.

## Test plan
- Single channel, NUM_CH=2: select[0]=1, addr=0x100 at cycle 0; mem_resp at cycle 4. Required: mem_req cycles 1–4, mem_addr=0x100, permit[0] cycle 1, done[0] and busy[0]=0 at cycle 4. Holding the same address afterwards gives no new mem_req.
- Hit/new address: after the 0x100 completion, change to 0x104. Required: busy[0] rises the same cycle, a new grant occurs, mem_addr=0x104.
- Round-robin: both channels pending continuously with new addresses each completion. Required grant order 0,1,0,1, with one IDLE cycle between transactions.
- inval coinciding with mem_resp for 0x200 on channel 1. Required: last_valid[1]=0 afterwards. Holding 0x200 re-issues 0x200.
- Mid-flight changes: channel 0 switches 0x300→0x304 during BUSY. Required: completion records 0x300, then 0x304 is issued. Separately, select drop mid-flight: done still pulses.
- Async reset in BUSY cycle 2. Required: mem_req=0 before the next edge, all records cleared. A mem_resp arriving after reset release has no effect.
